// File: rtl/alu_pkg.sv
// alu_pkg: funct codes, slice select encodings, issue FSM states and decoded-control type shared with the ALU slices
package alu_pkg;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                         FN_OR = 6'b100101, FN_SLT = 6'b101010;
  localparam logic [2:0] SEL_AND = 3'b000, SEL_OR = 3'b001, SEL_ADD = 3'b010,
                         SEL_SUB = 3'b110, SEL_SLT = 3'b111;
  localparam logic [1:0] ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2;
  typedef struct packed {
    logic [2:0] sel;
    logic       invert;
    logic       cin;
    logic       illegal;
  } ctrl_t;
  function automatic ctrl_t mk_ctrl(logic [2:0] sel, logic invert, logic cin, logic illegal);
    return '{sel: sel, invert: invert, cin: cin, illegal: illegal};
  endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: R-type funct to ALU slice controls (sel, B-invert, carry-in, illegal)
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);
  // sub and slt both compute A + ~B + 1; unknown functs become a harmless AND flagged illegal
  always_comb
    ctrl = (funct == FN_ADD) ? mk_ctrl(SEL_ADD, 1'b0, 1'b0, 1'b0) :
           (funct == FN_SUB) ? mk_ctrl(SEL_SUB, 1'b1, 1'b1, 1'b0) :
           (funct == FN_AND) ? mk_ctrl(SEL_AND, 1'b0, 1'b0, 1'b0) :
           (funct == FN_OR)  ? mk_ctrl(SEL_OR,  1'b0, 1'b0, 1'b0) :
           (funct == FN_SLT) ? mk_ctrl(SEL_SLT, 1'b1, 1'b1, 1'b0) :
                               mk_ctrl(SEL_AND, 1'b0, 1'b0, 1'b1);
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-at-input issue buffer feeding the ALU slices; define ALU_ISSUE_SKID_EN for a registered-ready two-entry skid build
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_sel,
  output logic              out_invert,
  output logic              out_cin,
  output logic              out_illegal,
  output logic [31:0]       issue_cnt
);
  ctrl_t             dec, head_c;
  logic [DATA_W-1:0] head_a, head_b;
  logic [1:0]        state, state_n;
  logic              in_hs, out_hs, load_in;
  alu_ctrl_decode u_dec (.funct(in_funct), .ctrl(dec));
  assign out_valid = state != ST_EMPTY;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign load_in   = !flush & in_hs & (state == ST_EMPTY | out_hs);
  // flush wins over any handshake; ONE->TWO only happens when the skid entry exists
  always_comb
    state_n = flush                ? ST_EMPTY :
              (state == ST_EMPTY)  ? (in_hs ? ST_ONE : ST_EMPTY) :
              (state == ST_ONE)    ? ((in_hs & !out_hs) ? ST_TWO : (out_hs & !in_hs) ? ST_EMPTY : ST_ONE) :
                                     (out_hs ? ST_ONE : ST_TWO);
  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_EMPTY;
    else     state <= state_n;
`ifdef ALU_ISSUE_SKID_EN
  ctrl_t             skid_c;
  logic [DATA_W-1:0] skid_a, skid_b;
  logic              rdy_q;
  assign in_ready = rdy_q;
  // skid catches the beat accepted while the head is stalled; ready is registered off the next state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      skid_a <= '0;
      skid_b <= '0;
      skid_c <= '0;
      rdy_q  <= 1'b1;
    end else begin
      rdy_q <= state_n != ST_TWO;
      if (!flush & state == ST_ONE & in_hs & !out_hs) begin
        skid_a <= in_rs;
        skid_b <= in_rt;
        skid_c <= dec;
      end
    end
`else
  assign in_ready = !out_valid | out_ready;
`endif
  // head entry: loads the new beat when empty or draining, or the skid entry when leaving TWO
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head_a <= '0;
      head_b <= '0;
      head_c <= '0;
    end else if (load_in) begin
      head_a <= in_rs;
      head_b <= in_rt;
      head_c <= dec;
    end
`ifdef ALU_ISSUE_SKID_EN
    else if (!flush & state == ST_TWO & out_hs) begin
      head_a <= skid_a;
      head_b <= skid_b;
      head_c <= skid_c;
    end
`endif
  // completed output handshakes, wrapping; a flushed cycle does not count
  always_ff @(posedge clk or posedge rst)
    if (rst)                  issue_cnt <= '0;
    else if (out_hs & !flush) issue_cnt <= issue_cnt + 32'd1;
  assign out_a       = out_valid ? head_a : '0;
  assign out_b       = out_valid ? head_b : '0;
  assign out_sel     = out_valid ? head_c.sel : 3'b000;
  assign out_invert  = out_valid & head_c.invert;
  assign out_cin     = out_valid & head_c.cin;
  assign out_illegal = out_valid & head_c.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage (default or ALU_ISSUE_SKID_EN build)
module tb_alu_issue_stage;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_invert, out_cin, out_illegal;
  logic [5:0]  in_funct = '0;
  logic [31:0] in_rs = '0, in_rt = '0, out_a, out_b, issue_cnt;
  logic [2:0]  out_sel;
  int          n_chk = 0, n_fail = 0;
  logic [5:0]  fn [4] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0]  xs [4] = '{3'b010, 3'b000, 3'b001, 3'b111};
  logic        xi [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  alu_issue_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_sel(out_sel),
    .out_invert(out_invert), .out_cin(out_cin), .out_illegal(out_illegal), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] s, input logic i,
                         input logic ill, input logic [31:0] a, input logic [31:0] b);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".ctrl"}, {26'd0, out_sel, out_invert, out_cin, out_illegal}, {26'd0, s, i, i, ill});
    chk({tag, ".a"}, out_a, a);
    chk({tag, ".b"}, out_b, b);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_funct = f;
    in_rs    = a;
    in_rt    = b;
  endtask

  initial begin
    #3;
    chk_out("reset", 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("reset.cnt", issue_cnt, 32'd0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    #9 rst = 1'b0;
    tick;
    // sub 5,3 with out_ready high
    out_ready = 1'b1;
    drive(1'b1, 6'b100010, 32'd5, 32'd3);
    tick;
    drive(1'b0, 6'b0, 32'd0, 32'd0);
    chk_out("sub", 1'b1, 3'b110, 1'b1, 1'b0, 32'd5, 32'd3);
    chk("sub.cnt_before", issue_cnt, 32'd0);
    tick;
    chk("sub.cnt", issue_cnt, 32'd1);
    chk_out("sub.drained", 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    // illegal funct passes operands through
    drive(1'b1, 6'b111111, 32'hAA, 32'h55);
    tick;
    drive(1'b0, 6'b0, 32'd0, 32'd0);
    chk_out("illegal", 1'b1, 3'b000, 1'b0, 1'b1, 32'hAA, 32'h55);
    tick;
    chk("illegal.cnt", issue_cnt, 32'd2);
    // back-to-back add/and/or/slt at full throughput
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, fn[k], 32'(100 + k), 32'(200 + k));
      tick;
      chk_out($sformatf("stream%0d", k), 1'b1, xs[k], xi[k], 1'b0, 32'(100 + k), 32'(200 + k));
      chk($sformatf("stream%0d.in_ready", k), {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 6'b0, 32'd0, 32'd0);
    tick;
    chk("stream.cnt", issue_cnt, 32'd6);
    chk("stream.empty", {31'd0, out_valid}, 32'd0);
    // stall three cycles with input still offered, then release
    out_ready = 1'b0;
    drive(1'b1, 6'b100000, 32'h11, 32'h22);
    tick;
    drive(1'b1, 6'b100101, 32'h33, 32'h44);
    chk_out("stall1", 1'b1, 3'b010, 1'b0, 1'b0, 32'h11, 32'h22);
`ifdef ALU_ISSUE_SKID_EN
    chk("stall1.in_ready", {31'd0, in_ready}, 32'd1);
`else
    chk("stall1.in_ready", {31'd0, in_ready}, 32'd0);
`endif
    tick;
    chk_out("stall2", 1'b1, 3'b010, 1'b0, 1'b0, 32'h11, 32'h22);
    chk("stall2.in_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk_out("stall3", 1'b1, 3'b010, 1'b0, 1'b0, 32'h11, 32'h22);
    chk("stall3.cnt", issue_cnt, 32'd6);
    out_ready = 1'b1;
    tick;
    drive(1'b0, 6'b0, 32'd0, 32'd0);
    chk_out("release", 1'b1, 3'b001, 1'b0, 1'b0, 32'h33, 32'h44);
    chk("release.cnt", issue_cnt, 32'd7);
    tick;
    chk("release.cnt2", issue_cnt, 32'd8);
    chk("release.empty", {31'd0, out_valid}, 32'd0);
    // flush with a simultaneous input and output handshake while in ONE
    out_ready = 1'b0;
    drive(1'b1, 6'b100010, 32'd7, 32'd2);
    tick;
    chk("flush.pre_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 6'b100000, 32'h99, 32'h98);
    tick;
    flush = 1'b0;
    drive(1'b0, 6'b0, 32'd0, 32'd0);
    chk_out("flush", 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("flush.cnt", issue_cnt, 32'd8);
    tick;
    chk("flush.dropped", {31'd0, out_valid}, 32'd0);
    chk("flush.cnt2", issue_cnt, 32'd8);
    // counter wrap from a preset value
    force dut.issue_cnt = 32'hFFFF_FFFE;
    #1 release dut.issue_cnt;
    drive(1'b1, 6'b100100, 32'd1, 32'd2);
    tick;
    drive(1'b1, 6'b100101, 32'd3, 32'd4);
    tick;
    drive(1'b0, 6'b0, 32'd0, 32'd0);
    chk("wrap.max", issue_cnt, 32'hFFFF_FFFF);
    chk_out("wrap.second", 1'b1, 3'b001, 1'b0, 1'b0, 32'd3, 32'd4);
    tick;
    chk("wrap.zero", issue_cnt, 32'd0);
    // asynchronous reset between edges while in ONE
    out_ready = 1'b0;
    drive(1'b1, 6'b101010, 32'h5A, 32'hA5);
    tick;
    drive(1'b0, 6'b0, 32'd0, 32'd0);
    chk("areset.pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_out("areset", 1'b0, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 rst = 1'b0;
    tick;
    chk("areset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("areset.after_valid", {31'd0, out_valid}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
